// File: rtl/purifier_pkg.sv
// Shared types and helpers for the air-cleaner run-time sequencer:
// one-hot state encodings and fan-level thermometer conversion.
package purifier_pkg;

    typedef enum logic [2:0] {
        ST_SET  = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    localparam logic [4:0] LVL_0 = 5'b00000;
    localparam logic [4:0] LVL_1 = 5'b00001;
    localparam logic [4:0] LVL_2 = 5'b00011;
    localparam logic [4:0] LVL_3 = 5'b00111;
    localparam logic [4:0] LVL_4 = 5'b01111;
    localparam logic [4:0] LVL_5 = 5'b11111;

    localparam logic [7:0] TIME_MAX = 8'd59;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } lvl_dec_t;

    // Thermometer code to level index; non-thermometer codes are flagged invalid.
    function automatic lvl_dec_t lvl_decode(input logic [4:0] code);
        lvl_dec_t d;
        d.valid = 1'b1;
        case (code)
            LVL_0:   d.idx = 3'd0;
            LVL_1:   d.idx = 3'd1;
            LVL_2:   d.idx = 3'd2;
            LVL_3:   d.idx = 3'd3;
            LVL_4:   d.idx = 3'd4;
            LVL_5:   d.idx = 3'd5;
            default: begin
                d.valid = 1'b0;
                d.idx   = 3'd0;
            end
        endcase
        return d;
    endfunction

    function automatic logic [4:0] lvl_encode(input logic [2:0] idx);
        logic [4:0] code;
        case (idx)
            3'd0:    code = LVL_0;
            3'd1:    code = LVL_1;
            3'd2:    code = LVL_2;
            3'd3:    code = LVL_3;
            3'd4:    code = LVL_4;
            3'd5:    code = LVL_5;
            default: code = LVL_0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/purifier_run_ctrl_tick_prescaler.sv
// Free-running divide-by-DIV counter with synchronous clear; tick is high
// for the one cycle in which the count sits at DIV-1.
module tick_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_r;

    // Divider count, wrapping at DIV-1 and restartable by clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + W'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/purifier_run_ctrl.sv
// Air-cleaner run-time sequencer: 1 Hz countdown of the keypad preset,
// SET/RUN/DONE status for the keypad, soft-ramped fan level and expiry buzzer.
module purifier_run_ctrl
    import purifier_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int RAMP_CYC = 10_000_000,
    parameter int BEEP_SEC = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    input  logic       count_begin,
    input  logic       stop_req,
    input  logic       sleep_flag,
    input  logic [4:0] level_req,
    output logic [2:0] state_flag,
    output logic [7:0] remain_min,
    output logic [7:0] remain_sec,
    output logic [4:0] fan_level,
    output logic       done_pulse,
    output logic       buzzer
);

    state_t     state_r;
    logic       cb_d_r;
    logic [7:0] beep_cnt_r;
    logic [2:0] lvl_idx_r;
    logic [2:0] tgt_idx_r;

    logic       start_s;
    logic       sec_tick_s;
    logic       sec_clr_s;
    logic       ramp_tick_s;
    logic [7:0] min_clamp_s;
    logic [7:0] sec_clamp_s;
    lvl_dec_t   dec_s;
    logic [2:0] tgt_nxt_s;
    logic [2:0] lvl_nxt_s;

    assign start_s     = count_begin & ~cb_d_r;
    assign min_clamp_s = (preset_min > TIME_MAX) ? TIME_MAX : preset_min;
    assign sec_clamp_s = (preset_sec > TIME_MAX) ? TIME_MAX : preset_sec;
    assign state_flag  = state_r;

    // Held at zero in SET so the first tick lands exactly one period into RUN.
    assign sec_clr_s = (state_r == ST_SET) ||
                       ((state_r == ST_DONE) && start_s && !stop_req);

    tick_prescaler #(.DIV(CLK_HZ)) u_sec_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sec_clr_s),
        .tick  (sec_tick_s)
    );

    tick_prescaler #(.DIV(RAMP_CYC)) u_ramp_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .tick  (ramp_tick_s)
    );

    // Sequencer state, countdown registers and expiry/buzzer outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_SET;
            cb_d_r     <= 1'b0;
            remain_min <= 8'd0;
            remain_sec <= 8'd0;
            done_pulse <= 1'b0;
            buzzer     <= 1'b0;
            beep_cnt_r <= 8'd0;
        end else begin
            cb_d_r     <= count_begin;
            done_pulse <= 1'b0;
            case (state_r)
                ST_SET: begin
                    remain_min <= min_clamp_s;
                    remain_sec <= sec_clamp_s;
                    buzzer     <= 1'b0;
                    if (start_s) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop_req) begin
                        state_r    <= ST_SET;
                        remain_min <= min_clamp_s;
                        remain_sec <= sec_clamp_s;
                    end else if ((remain_min == 8'd0) && (remain_sec == 8'd0)) begin
                        // A 00:00 preset expires without waiting for a tick.
                        state_r    <= ST_DONE;
                        done_pulse <= 1'b1;
                        buzzer     <= 1'b1;
                        beep_cnt_r <= 8'd0;
                    end else if (sec_tick_s) begin
                        if (remain_sec != 8'd0) begin
                            remain_sec <= remain_sec - 8'd1;
                        end else begin
                            remain_min <= remain_min - 8'd1;
                            remain_sec <= TIME_MAX;
                        end
                        if ((remain_min == 8'd0) && (remain_sec == 8'd1)) begin
                            state_r    <= ST_DONE;
                            done_pulse <= 1'b1;
                            buzzer     <= 1'b1;
                            beep_cnt_r <= 8'd0;
                        end
                    end
                end
                ST_DONE: begin
                    remain_min <= 8'd0;
                    remain_sec <= 8'd0;
                    if (stop_req) begin
                        state_r <= ST_SET;
                        buzzer  <= 1'b0;
                    end else if (start_s) begin
                        state_r    <= ST_RUN;
                        remain_min <= min_clamp_s;
                        remain_sec <= sec_clamp_s;
                        buzzer     <= 1'b0;
                    end else if (sec_tick_s && buzzer) begin
                        beep_cnt_r <= beep_cnt_r + 8'd1;
                        if (beep_cnt_r == 8'(BEEP_SEC - 1)) begin
                            buzzer <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_SET;
                    remain_min <= 8'd0;
                    remain_sec <= 8'd0;
                    buzzer     <= 1'b0;
                end
            endcase
        end
    end

    // Fan target selection; a malformed level request keeps the last target.
    always_comb begin
        tgt_nxt_s = tgt_idx_r;
        dec_s     = lvl_decode(level_req);
        case (state_r)
            ST_SET: begin
                if (dec_s.valid) begin
                    tgt_nxt_s = dec_s.idx;
                end else begin
                    tgt_nxt_s = tgt_idx_r;
                end
            end
            ST_RUN: begin
                if (sleep_flag) begin
                    tgt_nxt_s = 3'd1;
                end else if (dec_s.valid) begin
                    tgt_nxt_s = dec_s.idx;
                end else begin
                    tgt_nxt_s = tgt_idx_r;
                end
            end
            ST_DONE: tgt_nxt_s = 3'd0;
            default: tgt_nxt_s = 3'd0;
        endcase
    end

    // One-step soft ramp toward the target on each ramp tick.
    always_comb begin
        lvl_nxt_s = lvl_idx_r;
        if (ramp_tick_s) begin
            if (lvl_idx_r < tgt_idx_r) begin
                lvl_nxt_s = lvl_idx_r + 3'd1;
            end else if (lvl_idx_r > tgt_idx_r) begin
                lvl_nxt_s = lvl_idx_r - 3'd1;
            end else begin
                lvl_nxt_s = lvl_idx_r;
            end
        end else begin
            lvl_nxt_s = lvl_idx_r;
        end
    end

    // Fan level registers; the LED code is registered alongside its index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt_idx_r <= 3'd0;
            lvl_idx_r <= 3'd0;
            fan_level <= LVL_0;
        end else begin
            tgt_idx_r <= tgt_nxt_s;
            lvl_idx_r <= lvl_nxt_s;
            fan_level <= lvl_encode(lvl_nxt_s);
        end
    end

endmodule

// File: tb/tb_purifier_run_ctrl.sv
// Directed bench for purifier_run_ctrl with small timing parameters; expected
// values are queued when stimulus is applied and popped when the DUT responds.
module tb_purifier_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] preset_min;
    logic [7:0] preset_sec;
    logic       count_begin;
    logic       stop_req;
    logic       sleep_flag;
    logic [4:0] level_req;
    logic [2:0] state_flag;
    logic [7:0] remain_min;
    logic [7:0] remain_sec;
    logic [4:0] fan_level;
    logic       done_pulse;
    logic       buzzer;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    purifier_run_ctrl #(.CLK_HZ(10), .RAMP_CYC(2), .BEEP_SEC(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .preset_min  (preset_min),
        .preset_sec  (preset_sec),
        .count_begin (count_begin),
        .stop_req    (stop_req),
        .sleep_flag  (sleep_flag),
        .level_req   (level_req),
        .state_flag  (state_flag),
        .remain_min  (remain_min),
        .remain_sec  (remain_sec),
        .fan_level   (fan_level),
        .done_pulse  (done_pulse),
        .buzzer      (buzzer)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_pulse === 1'b1) done_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, obs);
        end else begin
            chk(tag, obs, {24'd0, exp_q.pop_front()});
        end
    endtask

    // Wait (bounded) for each fan change and score it; optionally check 2-cycle spacing.
    task automatic ramp_check(input string tag, input int n, input bit timed);
        logic [4:0] prev;
        int cyc;
        for (int i = 0; i < n; i++) begin
            prev = fan_level;
            cyc  = 0;
            while (fan_level === prev && cyc < 10) begin
                step(1);
                cyc++;
            end
            chk_pop(tag, {27'd0, fan_level});
            if (timed && i > 0) chk({tag, "_gap"}, cyc, 32'd2);
        end
    endtask

    initial begin
        int d0;
        int k;
        rst_n = 1'b0; preset_min = 8'd0; preset_sec = 8'd0; count_begin = 1'b0;
        stop_req = 1'b0; sleep_flag = 1'b0; level_req = 5'b11111;
        step(3);
        chk("rst_state", state_flag, 3'd1);
        chk("rst_min", remain_min, 8'd0);
        chk("rst_sec", remain_sec, 8'd0);
        chk("rst_fan", fan_level, 5'b00000);
        chk("rst_buzz", buzzer, 1'b0);
        chk("rst_done", done_pulse, 1'b0);
        rst_n = 1'b1;

        // Ramp up in SET, then an invalid code holds the level.
        exp_q.push_back(8'h01); exp_q.push_back(8'h03); exp_q.push_back(8'h07);
        exp_q.push_back(8'h0f); exp_q.push_back(8'h1f);
        ramp_check("ramp_up", 5, 1'b1);
        level_req = 5'b01010;
        step(6);
        chk("ramp_hold", fan_level, 5'b11111);

        // Preset clamp.
        preset_min = 8'd70; preset_sec = 8'd75;
        step(2);
        chk("clamp_min", remain_min, 8'd59);
        chk("clamp_sec", remain_sec, 8'd59);

        // 0:03 countdown to expiry and beep window.
        preset_min = 8'd0; preset_sec = 8'd3;
        step(1);
        d0 = done_cnt;
        count_begin = 1'b1;
        exp_q.push_back(8'd2); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
        step(1);
        chk("run_state", state_flag, 3'd2);
        step(10);
        chk_pop("cd_sec2", remain_sec);
        count_begin = 1'b0;
        step(10);
        chk_pop("cd_sec1", remain_sec);
        step(10);
        chk_pop("cd_sec0", remain_sec);
        chk("exp_done", done_pulse, 1'b1);
        chk("exp_state", state_flag, 3'd4);
        chk("exp_buzz", buzzer, 1'b1);
        step(1);
        chk("done_1cyc", done_pulse, 1'b0);
        step(18);
        chk("buzz_hold", buzzer, 1'b1);
        step(1);
        chk("buzz_off", buzzer, 1'b0);
        chk("done_once", done_cnt - d0, 32'd1);
        stop_req = 1'b1;
        step(1);
        stop_req = 1'b0;
        chk("stop_done", state_flag, 3'd1);

        // 1:00, stop coinciding with the second tick.
        preset_min = 8'd1; preset_sec = 8'd0;
        step(1);
        d0 = done_cnt;
        count_begin = 1'b1;
        exp_q.push_back(8'd0); exp_q.push_back(8'd59);
        step(1);
        chk("run2_state", state_flag, 3'd2);
        step(10);
        chk_pop("borrow_min", remain_min);
        chk_pop("borrow_sec", remain_sec);
        step(9);
        stop_req = 1'b1;
        step(1);
        stop_req = 1'b0;
        chk("stop_state", state_flag, 3'd1);
        step(1);
        chk("stop_min", remain_min, 8'd1);
        chk("stop_sec", remain_sec, 8'd0);
        chk("stop_nodone", done_cnt - d0, 32'd0);
        count_begin = 1'b0;

        // 0:00 preset: immediate expiry, fan ramps off.
        level_req = 5'b11111;
        exp_q.push_back(8'h01); exp_q.push_back(8'h03); exp_q.push_back(8'h07);
        exp_q.push_back(8'h0f); exp_q.push_back(8'h1f);
        ramp_check("ramp_set", 5, 1'b0);
        preset_min = 8'd0; preset_sec = 8'd0;
        step(1);
        d0 = done_cnt;
        count_begin = 1'b1;
        k = 0;
        while (state_flag !== 3'd4 && k < 3) begin
            step(1);
            k++;
        end
        chk("zero_state", state_flag, 3'd4);
        chk("zero_lat", (k >= 1 && k <= 2), 1'b1);
        exp_q.push_back(8'h0f); exp_q.push_back(8'h07); exp_q.push_back(8'h03);
        exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        ramp_check("ramp_off", 5, 1'b0);
        chk("zero_done", done_cnt - d0, 32'd1);

        // Sleep forces level 1 while running, then releases.
        count_begin = 1'b0;
        stop_req = 1'b1;
        step(1);
        stop_req = 1'b0;
        exp_q.push_back(8'h01); exp_q.push_back(8'h03); exp_q.push_back(8'h07);
        exp_q.push_back(8'h0f); exp_q.push_back(8'h1f);
        ramp_check("ramp_set2", 5, 1'b0);
        sleep_flag = 1'b1;
        preset_min = 8'd5; preset_sec = 8'd0;
        step(1);
        count_begin = 1'b1;
        step(1);
        chk("sleep_run", state_flag, 3'd2);
        exp_q.push_back(8'h0f); exp_q.push_back(8'h07); exp_q.push_back(8'h03);
        exp_q.push_back(8'h01);
        ramp_check("sleep_dn", 4, 1'b0);
        step(6);
        chk("sleep_hold", fan_level, 5'b00001);
        sleep_flag = 1'b0;
        exp_q.push_back(8'h03); exp_q.push_back(8'h07); exp_q.push_back(8'h0f);
        exp_q.push_back(8'h1f);
        ramp_check("sleep_up", 4, 1'b0);

        // Reset pulse in the middle of a 0:05 run.
        count_begin = 1'b0;
        stop_req = 1'b1;
        step(1);
        stop_req = 1'b0;
        preset_min = 8'd0; preset_sec = 8'd5;
        step(1);
        d0 = done_cnt;
        count_begin = 1'b1;
        exp_q.push_back(8'd4);
        step(11);
        chk_pop("mid_sec", remain_sec);
        rst_n = 1'b0;
        step(1);
        chk("mrst_state", state_flag, 3'd1);
        chk("mrst_min", remain_min, 8'd0);
        chk("mrst_sec", remain_sec, 8'd0);
        chk("mrst_fan", fan_level, 5'b00000);
        chk("mrst_buzz", buzzer, 1'b0);
        rst_n = 1'b1;
        step(2);
        chk("mrst_nodone", done_cnt - d0, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
